// File: rtl/key_sequence_transmitter_if.sv
// Handshake bundle between the key transmitter and its controller / lock.
// The master side drives the request and the lock response; the slave is the transmitter.
interface key_sequence_transmitter_if #(
    parameter int unsigned KEY_W = 8,
    parameter int unsigned CNT_W = 4
);
    logic [1:KEY_W]   key;
    logic             send;
    logic             abort;
    logic             unlock_in;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic             success;
    logic             fail;
    logic [CNT_W-1:0] attempt_cnt;

    modport master (
        output key, send, abort, unlock_in,
        input  x_out, x_valid, busy, done, success, fail, attempt_cnt
    );

    modport slave (
        input  key, send, abort, unlock_in,
        output x_out, x_valid, busy, done, success, fail, attempt_cnt
    );
endinterface

// File: rtl/key_sequence_transmitter.sv
// Serializes a captured key onto a code lock's input, waits for unlock and retries on timeout.
// All outputs are registered; next-state values are computed in a single combinational process.
module key_sequence_transmitter #(
    parameter int unsigned KEY_W        = 8,
    parameter int unsigned RESP_TIMEOUT = 4,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned CNT_W        = 4
) (
    input logic                   clock,
    input logic                   reset,
    key_sequence_transmitter_if.slave bus
);
    localparam int unsigned BIT_W  = $clog2(KEY_W + 1);
    localparam int unsigned WAIT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StShift, StWait} state_e;

    state_e             r_state,   w_state_d;
    logic [1:KEY_W]     r_key,     w_key_d;
    logic [1:KEY_W]     r_sh,      w_sh_d;
    logic [BIT_W-1:0]   r_bit,     w_bit_d;
    logic [WAIT_W-1:0]  r_wait,    w_wait_d;
    logic [CNT_W-1:0]   r_attempt, w_attempt_d;
    logic               r_x_out,   w_x_out_d;
    logic               r_x_valid, w_x_valid_d;
    logic               r_busy,    w_busy_d;
    logic               r_done,    w_done_d;
    logic               r_success, w_success_d;
    logic               r_fail,    w_fail_d;

    always_comb begin
        w_state_d   = r_state;
        w_key_d     = r_key;
        w_sh_d      = r_sh;
        w_bit_d     = r_bit;
        w_wait_d    = r_wait;
        w_attempt_d = r_attempt;
        w_x_out_d   = 1'b0;
        w_x_valid_d = 1'b0;
        w_done_d    = 1'b0;
        w_success_d = r_success;
        w_fail_d    = r_fail;

        if (bus.abort) begin
            // Cancel keeps the sticky result flags of the previous request.
            w_state_d   = StIdle;
            w_attempt_d = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.send) begin
                        w_key_d     = bus.key;
                        w_sh_d      = bus.key << 1;
                        w_x_out_d   = bus.key[1];
                        w_x_valid_d = 1'b1;
                        w_bit_d     = BIT_W'(1);
                        w_attempt_d = CNT_W'(1);
                        w_success_d = 1'b0;
                        w_fail_d    = 1'b0;
                        w_state_d   = StShift;
                    end
                end
                StShift: begin
                    // r_bit is the index of the bit currently on x_out.
                    if (r_bit == BIT_W'(KEY_W)) begin
                        w_state_d = StWait;
                        w_wait_d  = WAIT_W'(1);
                    end else begin
                        w_x_out_d   = r_sh[1];
                        w_x_valid_d = 1'b1;
                        w_sh_d      = r_sh << 1;
                        w_bit_d     = r_bit + BIT_W'(1);
                    end
                end
                StWait: begin
                    if (bus.unlock_in) begin
                        w_state_d   = StIdle;
                        w_done_d    = 1'b1;
                        w_success_d = 1'b1;
                    end else if (r_wait == WAIT_W'(RESP_TIMEOUT)) begin
                        if (r_attempt < CNT_W'(MAX_TRIES)) begin
                            w_state_d   = StShift;
                            w_sh_d      = r_key << 1;
                            w_x_out_d   = r_key[1];
                            w_x_valid_d = 1'b1;
                            w_bit_d     = BIT_W'(1);
                            w_attempt_d = r_attempt + CNT_W'(1);
                        end else begin
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                            w_fail_d  = 1'b1;
                        end
                    end else begin
                        w_wait_d = r_wait + WAIT_W'(1);
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_key     <= '0;
            r_sh      <= '0;
            r_bit     <= '0;
            r_wait    <= '0;
            r_attempt <= '0;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_key     <= w_key_d;
            r_sh      <= w_sh_d;
            r_bit     <= w_bit_d;
            r_wait    <= w_wait_d;
            r_attempt <= w_attempt_d;
            r_x_out   <= w_x_out_d;
            r_x_valid <= w_x_valid_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_success <= w_success_d;
            r_fail    <= w_fail_d;
        end
    end

    assign bus.x_out       = r_x_out;
    assign bus.x_valid     = r_x_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.success     = r_success;
    assign bus.fail        = r_fail;
    assign bus.attempt_cnt = r_attempt;
endmodule

// File: tb/tb_key_sequence_transmitter.sv
// Directed bench for key_sequence_transmitter with default parameters (8-bit key, timeout 4,
// three tries). Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_key_sequence_transmitter;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    key_sequence_transmitter_if #(.KEY_W(8), .CNT_W(4)) bus ();

    key_sequence_transmitter #(
        .KEY_W        (8),
        .RESP_TIMEOUT (4),
        .MAX_TRIES    (3),
        .CNT_W        (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one 8-bit burst starting at its first bit; mode 1 disturbs key/send at bit 3,
    // mode 2 pulses unlock_in at bit 5. Leaves the bench in the first WAIT cycle.
    task automatic burst(input logic [7:0] k, input int att, input int mode);
        for (int i = 0; i < 8; i++) begin
            check("burst_bit", 32'(bus.x_out), 32'(k[7-i]));
            check("burst_valid", 32'(bus.x_valid), 32'd1);
            check("burst_attempt", 32'(bus.attempt_cnt), 32'(att));
            if (mode == 1 && i == 2) begin
                bus.key  = ~k;
                bus.send = 1'b1;
            end
            if (mode == 2 && i == 4) bus.unlock_in = 1'b1;
            tick();
            bus.send      = 1'b0;
            bus.unlock_in = 1'b0;
        end
    endtask

    task automatic wait_phase(input int n);
        for (int i = 0; i < n; i++) begin
            check("wait_valid", 32'(bus.x_valid), 32'd0);
            check("wait_xout", 32'(bus.x_out), 32'd0);
            check("wait_busy", 32'(bus.busy), 32'd1);
            check("wait_done", 32'(bus.done), 32'd0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] kc3;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.key       = 8'b1011_0010;
        bus.send      = 1'b1;
        bus.abort     = 1'b0;
        bus.unlock_in = 1'b0;

        // Reset held with send high: nothing starts.
        tick(); tick(); tick();
        check("rst_flags", 32'({bus.x_out, bus.x_valid, bus.busy, bus.done,
                                bus.success, bus.fail}), 32'd0);
        check("rst_attempt", 32'(bus.attempt_cnt), 32'd0);
        reset    = 1'b0;
        bus.send = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_valid", 32'(bus.x_valid), 32'd0);

        // Single transmission, unlock in the first WAIT cycle.
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        burst(8'b1011_0010, 1, 0);
        check("t2_wait_valid", 32'(bus.x_valid), 32'd0);
        check("t2_wait_busy", 32'(bus.busy), 32'd1);
        bus.unlock_in = 1'b1;
        tick();
        bus.unlock_in = 1'b0;
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_success", 32'(bus.success), 32'd1);
        check("t2_fail", 32'(bus.fail), 32'd0);
        check("t2_busy", 32'(bus.busy), 32'd0);
        check("t2_attempt", 32'(bus.attempt_cnt), 32'd1);
        tick();
        check("t2_done_pulse", 32'(bus.done), 32'd0);
        check("t2_success_sticky", 32'(bus.success), 32'd1);
        check("t2_attempt_hold", 32'(bus.attempt_cnt), 32'd1);

        // Abort in IDLE keeps success but clears the attempt count.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("idle_abort_success", 32'(bus.success), 32'd1);
        check("idle_abort_attempt", 32'(bus.attempt_cnt), 32'd0);
        check("idle_abort_done", 32'(bus.done), 32'd0);

        // No unlock: three tries then fail; the 2nd burst is disturbed by key/send changes.
        bus.key  = 8'b1011_0010;
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        check("t3_success_clr", 32'(bus.success), 32'd0);
        check("t3_fail_clr", 32'(bus.fail), 32'd0);
        burst(8'b1011_0010, 1, 0);
        wait_phase(4);
        burst(8'b1011_0010, 2, 1);
        wait_phase(4);
        burst(8'b1011_0010, 3, 0);
        wait_phase(4);
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_fail", 32'(bus.fail), 32'd1);
        check("t3_success", 32'(bus.success), 32'd0);
        check("t3_busy", 32'(bus.busy), 32'd0);
        check("t3_attempt", 32'(bus.attempt_cnt), 32'd3);
        tick();
        check("t3_done_pulse", 32'(bus.done), 32'd0);
        check("t3_fail_sticky", 32'(bus.fail), 32'd1);

        // Reset clears the sticky fail flag.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_fail", 32'(bus.fail), 32'd0);
        check("rst2_attempt", 32'(bus.attempt_cnt), 32'd0);

        // unlock_in during SHIFT is ignored; unlock in the 4th WAIT cycle wins over timeout.
        bus.key  = 8'h5A;
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        burst(8'h5A, 1, 2);
        wait_phase(4);
        burst(8'h5A, 2, 0);
        wait_phase(3);
        bus.unlock_in = 1'b1;
        tick();
        bus.unlock_in = 1'b0;
        check("t5_done", 32'(bus.done), 32'd1);
        check("t5_success", 32'(bus.success), 32'd1);
        check("t5_attempt", 32'(bus.attempt_cnt), 32'd2);
        check("t5_valid", 32'(bus.x_valid), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);

        // Send in the done cycle is accepted, then abort at the 5th bit.
        kc3      = 8'hC3;
        bus.key  = kc3;
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        check("t6_done_clr", 32'(bus.done), 32'd0);
        check("t6_success_clr", 32'(bus.success), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd1);
        check("t6_bit1", 32'(bus.x_out), 32'd1);
        check("t6_attempt", 32'(bus.attempt_cnt), 32'd1);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("t6_bit", 32'(bus.x_out), 32'(kc3[7-i]));
            check("t6_valid", 32'(bus.x_valid), 32'd1);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_flags", 32'({bus.x_out, bus.x_valid, bus.busy, bus.done,
                                  bus.success, bus.fail}), 32'd0);
        check("abort_attempt", 32'(bus.attempt_cnt), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_quiet", 32'({bus.x_valid, bus.busy, bus.done}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
